mem_arbiter: RTL

- Shares the single-ported unified memory between instruction fetch and the data-memory access path driven by MemEnable/MemWr from the decoder.
- Fixed priority: data first, with a fetch starvation guard.
- Registered, one-transaction-at-a-time request/done handshake; stall outputs feed the pipeline.
- Watchdog timeout reports a sticky error.

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-ported memory between instruction fetch and data access.
// Data requests win by default. A fetch that keeps losing is forced through after STARVE losses.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64,
  parameter int STARVE  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          halt,
  input  logic          dm_en,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT, ERR} state_e;

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int SCW = $clog2(STARVE + 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE);

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
  logic           mem_en_q, mem_en_d;
  logic           mem_wr_q, mem_wr_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           if_done_q, if_done_d;
  logic           dm_done_q, dm_done_d;
  logic [DW-1:0]  if_rdata_q, if_rdata_d;
  logic [DW-1:0]  dm_rdata_q, dm_rdata_d;
  logic           err_q, err_d;

  logic dm_elig, if_elig, grant_if, grant_dm, mem_ack, timeout_hit;

  // A requester is not eligible in its own done cycle, so a held request is not re-served.
  assign dm_elig     = dm_en & ~dm_done_q;
  assign if_elig     = if_req & ~if_done_q & ~halt;
  assign grant_if    = (state_q == IDLE) & if_elig & (~dm_elig | (starve_cnt_q == STARVE_MAX));
  assign grant_dm    = (state_q == IDLE) & dm_elig & ~grant_if;
  // A done seen while the start strobe is still out cannot belong to this transaction.
  assign mem_ack     = mem_done & ~mem_en_q;
  assign timeout_hit = (wait_cnt_q == WAIT_LAST);

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case leaves a latch.
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_en_d     = 1'b0;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d      = IF_WAIT;
          mem_en_d     = 1'b1;
          mem_wr_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          wait_cnt_d   = '0;
          starve_cnt_d = '0;
        end else if (grant_dm) begin
          state_d     = DM_WAIT;
          mem_en_d    = 1'b1;
          mem_wr_d    = dm_wr;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          wait_cnt_d  = '0;
          if (if_elig && starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
        end
      end
      IF_WAIT, DM_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (mem_ack) begin
          state_d = IDLE;
          if (state_q == IF_WAIT) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            dm_done_d = 1'b1;
            if (!mem_wr_q) dm_rdata_d = mem_rdata;
          end
        end else if (timeout_hit) begin
          // Release the stalled requester with zero data; the error stays until reset.
          state_d = ERR;
          err_d   = 1'b1;
          if (state_q == IF_WAIT) begin
            if_rdata_d = '0;
            if_done_d  = 1'b1;
          end else begin
            dm_rdata_d = '0;
            dm_done_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (!if_req) starve_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      err_q        <= err_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = dm_en & ~dm_done_q;

endmodule
